// File: rtl/tl_pkg.sv
// Shared TileLink-UL types and the response formatting helpers used by the
// channel D responder.
package tl_pkg;

  localparam int unsigned TL_SRC_W = 2;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } size_e;

  typedef struct packed {
    d_opcode_e             opcode;
    size_e                 size;
    logic [TL_SRC_W-1:0]   source;
    logic                  error;
    logic [31:0]           data;
  } d_beat_t;

  // Right-justify the addressed lanes and zero everything above the size.
  function automatic logic [31:0] extract_data(input logic [31:0] rdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  addr);
    logic [31:0] shifted;
    shifted = rdata >> {addr, 3'b000};
    case (size)
      SIZE_BYTE: extract_data = {24'h0, shifted[7:0]};
      SIZE_HALF: extract_data = {16'h0, shifted[15:0]};
      default:   extract_data = shifted;
    endcase
  endfunction

  function automatic logic access_error(input logic [2:0] a_opcode,
                                        input logic [1:0] size,
                                        input logic [1:0] addr);
    logic bad_op;
    logic bad_align;
    bad_op    = !(a_opcode == A_PUT_FULL || a_opcode == A_PUT_PARTIAL ||
                  a_opcode == A_GET);
    bad_align = (size == SIZE_ILLEGAL) ||
                (size == SIZE_HALF && addr[0]) ||
                (size == SIZE_WORD && addr != 2'd0);
    access_error = bad_op || bad_align;
  endfunction

endpackage

// File: rtl/tl_d_fifo.sv
// DEPTH-entry FIFO of formatted D beats; head is always visible on head_o.
module tl_d_fifo
  import tl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  d_beat_t data_i,
  input  logic    pop_i,
  output d_beat_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  d_beat_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr];

  // Storage is cleared on reset so an empty FIFO presents an all-zero head.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tl_d_responder.sv
// TileLink-UL channel D transmitter: formats device results at push time,
// queues them, and drives them toward the host with valid/ready backpressure.
module tl_d_responder
  import tl_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned SRC_W    = TL_SRC_W,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  input  logic [2:0]          rsp_a_opcode_i,
  input  logic [1:0]          rsp_size_i,
  input  logic [1:0]          rsp_addr_i,
  input  logic [SRC_W-1:0]    rsp_source_i,
  input  logic [31:0]         rsp_rdata_i,
  output logic                d_valid_o,
  input  logic                d_ready_i,
  output logic [2:0]          d_opcode_o,
  output logic [1:0]          d_size_o,
  output logic [SRC_W-1:0]    d_source_o,
  output logic                d_error_o,
  output logic [31:0]         d_data_o,
  output logic [ERRCNT_W-1:0] err_count_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and a beat held with ready low stays
  // stable until taken.

  d_beat_t             beat_in;
  d_beat_t             head;
  logic                full;
  logic                empty;
  logic                pop;
  logic                is_err;
  logic [ERRCNT_W-1:0] err_count;

  always_comb begin
    beat_in        = '0;
    is_err         = access_error(rsp_a_opcode_i, rsp_size_i, rsp_addr_i);
    beat_in.opcode = (rsp_a_opcode_i == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
    beat_in.size   = size_e'(rsp_size_i);
    beat_in.source = rsp_source_i;
    beat_in.error  = is_err;
    if (!is_err && rsp_a_opcode_i == A_GET)
      beat_in.data = extract_data(rsp_rdata_i, rsp_size_i, rsp_addr_i);
  end

  tl_d_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rsp_valid_i),
    .data_i  (beat_in),
    .pop_i   (d_ready_i),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rsp_ready_o = !full;
  assign d_valid_o   = !empty;
  assign pop         = d_valid_o && d_ready_i;

  assign d_opcode_o  = head.opcode;
  assign d_size_o    = head.size;
  assign d_source_o  = head.source;
  assign d_error_o   = head.error;
  assign d_data_o    = head.data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_count <= '0;
    end else if (pop && head.error && err_count != '1) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign err_count_o = err_count;

endmodule

// File: tb/tb_tl_d_responder.sv
// Directed bench for tl_d_responder with hand-computed expected beats.
module tb_tl_d_responder;

  logic        clk_i;
  logic        rst_i;
  logic        rsp_valid_i;
  logic        rsp_ready_o;
  logic [2:0]  rsp_a_opcode_i;
  logic [1:0]  rsp_size_i;
  logic [1:0]  rsp_addr_i;
  logic [1:0]  rsp_source_i;
  logic [31:0] rsp_rdata_i;
  logic        d_valid_o;
  logic        d_ready_i;
  logic [2:0]  d_opcode_o;
  logic [1:0]  d_size_o;
  logic [1:0]  d_source_o;
  logic        d_error_o;
  logic [31:0] d_data_o;
  logic [7:0]  err_count_o;

  int checks = 0;
  int errors = 0;

  tl_d_responder #(.DEPTH(2), .SRC_W(2), .ERRCNT_W(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rsp_valid_i    (rsp_valid_i),
    .rsp_ready_o    (rsp_ready_o),
    .rsp_a_opcode_i (rsp_a_opcode_i),
    .rsp_size_i     (rsp_size_i),
    .rsp_addr_i     (rsp_addr_i),
    .rsp_source_i   (rsp_source_i),
    .rsp_rdata_i    (rsp_rdata_i),
    .d_valid_o      (d_valid_o),
    .d_ready_i      (d_ready_i),
    .d_opcode_o     (d_opcode_o),
    .d_size_o       (d_size_o),
    .d_source_o     (d_source_o),
    .d_error_o      (d_error_o),
    .d_data_o       (d_data_o),
    .err_count_o    (err_count_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] sz, input logic [1:0] ad,
                       input logic [1:0] src, input logic [31:0] dat);
    rsp_a_opcode_i = op;
    rsp_size_i     = sz;
    rsp_addr_i     = ad;
    rsp_source_i   = src;
    rsp_rdata_i    = dat;
    rsp_valid_i    = 1'b1;
  endtask

  // One-cycle push; returns on the falling edge after the capturing edge.
  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [1:0] ad,
                      input logic [1:0] src, input logic [31:0] dat);
    @(negedge clk_i);
    drive(op, sz, ad, src, dat);
    @(negedge clk_i);
    rsp_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    rsp_valid_i = 1'b0;
    d_ready_i = 1'b0;
    drive(3'd0, 2'd0, 2'd0, 2'd0, 32'h0);
    rsp_valid_i = 1'b0;
    #12;
    check("rst_valid", {31'b0, d_valid_o}, 32'd0);
    check("rst_opcode", {29'b0, d_opcode_o}, 32'd0);
    check("rst_data", d_data_o, 32'd0);
    check("rst_errcnt", {24'b0, err_count_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_ready", {31'b0, rsp_ready_o}, 32'd1);

    d_ready_i = 1'b1;
    send(3'd4, 2'd2, 2'd0, 2'd1, 32'hDEADBEEF);
    check("get_w_valid", {31'b0, d_valid_o}, 32'd1);
    check("get_w_opcode", {29'b0, d_opcode_o}, 32'd1);
    check("get_w_data", d_data_o, 32'hDEADBEEF);
    check("get_w_err", {31'b0, d_error_o}, 32'd0);
    check("get_w_src", {30'b0, d_source_o}, 32'd1);
    @(negedge clk_i);
    check("get_w_popped", {31'b0, d_valid_o}, 32'd0);

    send(3'd4, 2'd0, 2'd3, 2'd0, 32'hA1B2C3D4);
    check("get_b3_data", d_data_o, 32'h000000A1);
    check("get_b3_size", {30'b0, d_size_o}, 32'd0);
    send(3'd4, 2'd1, 2'd2, 2'd0, 32'hA1B2C3D4);
    check("get_h2_data", d_data_o, 32'h0000A1B2);
    send(3'd4, 2'd0, 2'd1, 2'd0, 32'hA1B2C3D4);
    check("get_b1_data", d_data_o, 32'h000000C3);

    send(3'd0, 2'd2, 2'd0, 2'd2, 32'h12345678);
    check("put_opcode", {29'b0, d_opcode_o}, 32'd0);
    check("put_data", d_data_o, 32'd0);
    check("put_src", {30'b0, d_source_o}, 32'd2);
    check("put_err", {31'b0, d_error_o}, 32'd0);

    send(3'd4, 2'd1, 2'd1, 2'd3, 32'hFFFFFFFF);
    check("mis_err", {31'b0, d_error_o}, 32'd1);
    check("mis_opcode", {29'b0, d_opcode_o}, 32'd1);
    check("mis_data", d_data_o, 32'd0);
    check("mis_cnt_pre", {24'b0, err_count_o}, 32'd0);
    @(negedge clk_i);
    check("mis_cnt_post", {24'b0, err_count_o}, 32'd1);

    send(3'd5, 2'd2, 2'd0, 2'd0, 32'hFFFFFFFF);
    check("badop_err", {31'b0, d_error_o}, 32'd1);
    check("badop_opcode", {29'b0, d_opcode_o}, 32'd0);
    send(3'd1, 2'd2, 2'd2, 2'd0, 32'hFFFFFFFF);
    check("put_mis_err", {31'b0, d_error_o}, 32'd1);
    @(negedge clk_i);
    check("cnt_3", {24'b0, err_count_o}, 32'd3);

    for (int i = 0; i < 251; i++) send(3'd4, 2'd3, 2'd0, 2'd0, 32'h0);
    @(negedge clk_i);
    check("cnt_254", {24'b0, err_count_o}, 32'd254);
    for (int i = 0; i < 2; i++) send(3'd4, 2'd3, 2'd0, 2'd0, 32'h0);
    @(negedge clk_i);
    check("cnt_sat", {24'b0, err_count_o}, 32'd255);

    d_ready_i = 1'b0;
    @(negedge clk_i);
    drive(3'd4, 2'd2, 2'd0, 2'd0, 32'h11111111);
    @(negedge clk_i);
    check("bp_ready1", {31'b0, rsp_ready_o}, 32'd1);
    check("bp_head1", d_data_o, 32'h11111111);
    drive(3'd4, 2'd2, 2'd0, 2'd1, 32'h22222222);
    @(negedge clk_i);
    check("bp_full", {31'b0, rsp_ready_o}, 32'd0);
    drive(3'd4, 2'd2, 2'd0, 2'd2, 32'h33333333);
    @(negedge clk_i);
    check("bp_still_full", {31'b0, rsp_ready_o}, 32'd0);
    check("bp_head_stable", d_data_o, 32'h11111111);
    check("bp_src_stable", {30'b0, d_source_o}, 32'd0);
    d_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_out2", d_data_o, 32'h22222222);
    check("bp_ready_again", {31'b0, rsp_ready_o}, 32'd1);
    @(negedge clk_i);
    rsp_valid_i = 1'b0;
    d_ready_i = 1'b0;
    check("bp_out3", d_data_o, 32'h33333333);
    check("bp_src3", {30'b0, d_source_o}, 32'd2);
    @(negedge clk_i);
    check("bp_cnt1_valid", {31'b0, d_valid_o}, 32'd1);
    check("bp_cnt1_ready", {31'b0, rsp_ready_o}, 32'd1);
    d_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_drained", {31'b0, d_valid_o}, 32'd0);

    d_ready_i = 1'b0;
    send(3'd4, 2'd2, 2'd0, 2'd0, 32'hAAAA5555);
    send(3'd4, 2'd2, 2'd0, 2'd0, 32'h5555AAAA);
    check("pre_rst_full", {31'b0, rsp_ready_o}, 32'd0);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_valid", {31'b0, d_valid_o}, 32'd0);
    check("arst_errcnt", {24'b0, err_count_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("arst_ready", {31'b0, rsp_ready_o}, 32'd1);
    d_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("arst_no_stale", {31'b0, d_valid_o}, 32'd0);
    check("arst_data0", d_data_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_d_responder.md
Name: tl_d_responder

Overview:
Device-side TileLink-UL channel D transmitter. It accepts completed access results from a memory or peripheral, formats them into D-channel beats, and buffers them in a small FIFO. It drives d_valid/d_opcode/d_size/d_data toward the host-side channel D receiver with full valid/ready backpressure. It is the producing end of the D channel consumed by the core's load/store path.

Parameters:
DEPTH, 2, response FIFO entries (power of two, >=2)
SRC_W, 2, width of source ID returned on d_source_o
ERRCNT_W, 8, width of saturating error counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
rsp_valid_i  input  1  device presents a completed access
rsp_ready_o  output  1  responder can accept (FIFO not full)
rsp_a_opcode_i  input  3  originating A opcode (0 PutFullData, 1 PutPartialData, 4 Get)
rsp_size_i  input  2  originating a_size (0 byte, 1 half, 2 word, 3 illegal)
rsp_addr_i  input  2  originating address bits [1:0]
rsp_source_i  input  SRC_W  originating a_source
rsp_rdata_i  input  32  raw 32-bit word read from device (ignored for Puts)
d_valid_o  output  1  D beat valid
d_ready_i  input  1  host accepts D beat
d_opcode_o  output  3  0 AccessAck, 1 AccessAckData
d_size_o  output  2  echo of rsp_size_i
d_source_o  output  SRC_W  echo of rsp_source_i
d_error_o  output  1  access error
d_data_o  output  32  right-justified, zero-extended response data
err_count_o  output  ERRCNT_W  saturating count of error beats issued

Behaviour:
- Reset (async, rst_i=1): FIFO emptied, d_valid_o=0, d_opcode_o=0, d_size_o=0, d_source_o=0, d_error_o=0, d_data_o=0, err_count_o=0. rsp_ready_o=1 once rst_i deasserts. Reset mid-transfer discards all buffered beats; no beat is replayed.
- Push: rsp_valid_i & rsp_ready_o on edge N writes the formatted entry. Earliest d_valid_o is cycle N+1. There is no combinational bypass.
- rsp_ready_o = (count != DEPTH), registered-derived, with no dependence on d_ready_i.
- Pop: d_valid_o & d_ready_i on an edge retires the head. d_valid_o = (count != 0). While d_valid_o=1 and d_ready_i=0, all d_* outputs stay stable.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, pointers both advance. When count==0, a push-only increment occurs, since pop is impossible. When count==DEPTH, push is blocked.
- Pointers are log2(DEPTH) bits wide, wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.
- Formatting is done at push time and stored in the FIFO:
  - Get -> opcode 1. Data = rsp_rdata_i >> (8*addr[1:0]), masked to size: byte [7:0], half [15:0], word [31:0], upper bits zeroed.
  - PutFullData/PutPartialData -> opcode 0, data 0.
  - Error when any of: size==3; misaligned (half with addr[0]=1, word with addr!=0); illegal a_opcode (2,3,5,6,7). An error sets d_error_o=1 and data 0. Opcode is 1 if a_opcode==4, else 0.
- err_count_o increments on each popped beat with d_error_o=1 and saturates at all-ones.

Decomposition:
- tl_pkg: a_opcode_e (PutFullData=0, PutPartialData=1, Get=4), d_opcode_e (AccessAck=0, AccessAckData=1), size_e, d_beat_t struct {opcode, size, source, error, data}.
- Sub-module tl_d_fifo: generic DEPTH-entry FIFO of d_beat_t with push/pop/full/empty.
- The top level holds the formatting logic and the error counter.

Test Plan:
- Get, size 2, addr 0, rdata 32'hDEADBEEF, d_ready_i=1 -> next cycle d_valid_o=1, opcode 1, data 32'hDEADBEEF, error 0.
- Get, size 0, addr 3, rdata 32'hA1B2C3D4 -> data 32'h000000A1. Get, size 1, addr 2 -> data 32'h0000A1B2.
- PutFullData, size 2, source 2 -> opcode 0, data 0, d_source_o=2, error 0.
- Get, size 1, addr 1 -> error 1, opcode 1, data 0, err_count_o goes 0->1 after pop. 256 such pops (ERRCNT_W=8) -> err_count_o holds 255.
- d_ready_i=0, push 3 beats -> rsp_ready_o=0 after 2 pushes, head stable. Raise d_ready_i -> beats emerge in order. Simultaneous push/pop at count 1 leaves count 1.
- Assert rst_i asynchronously with 2 beats queued -> d_valid_o=0 immediately, rsp_ready_o=1 after release, no stale beat appears.
